seven_seg_reader: RTL and testbench
===================================

// Module: seven_seg_reader
// PURPOSE
//   Receive side of the 8-bit seven-segment LED bus driven by the BCD counter/encoder.
//   Samples the segment pattern and waits for it to be stable for STABLE_CYCLES.
//   Decodes each newly stable pattern back to BCD and checks that digits arrive in
//   count order (0..9, wrapping). Used as an on-board self-check and as a loopback monitor.
// PARAMETERS
//   STABLE_CYCLES  16  consecutive identical samples required to accept a pattern (>=2)
//   CNT_W          5   width of stability counter; must hold STABLE_CYCLES-1
//   SEQ_CHECK      1   1 = enable ordering check (seq_err); 0 = seq_err tied low
// PORTS
//   clk          in   1   system clock (50 MHz)
//   rst          in   1   synchronous reset, active-high
//   seg_in       in   8   segment pattern: bit7=a .. bit1=g, bit0=dp (dp ignored)
//   digit_valid  out  1   one-cycle pulse: new digit accepted
//   digit        out  4   BCD of last accepted digit; held between pulses
//   pattern_err  out  1   one-cycle pulse: stable pattern not in table and not blank
//   seq_err      out  1   one-cycle pulse, coincident with digit_valid: out-of-order digit
//   locked       out  1   high while a valid digit is held and no blank/error has followed
//   digit_count  out  16  accepted digits since reset, saturating at 16'hFFFF
//   err_count    out  8   pattern_err + seq_err events, saturating at 8'hFF (both in one cycle = +2)
// BEHAVIOUR
//   - All outputs and state are 0 after reset; state=EMPTY. Reset wins over any concurrent event.
//   - Input stage: seg_q <= seg_in & 8'hFE on every clk. No other logic acts on seg_in.
//   - Stability counter: if seg_q != seg_prev, then cnt <= 0. Else, if cnt != STABLE_CYCLES-1,
//     then cnt++. seg_prev <= seg_q.
//   - A pattern is stable when cnt == STABLE_CYCLES-1. Latency: a change sampled at edge N
//     is judged at edge N+STABLE_CYCLES. Output pulses are high during the cycle after that edge.
//   - Decode table: 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=F6. 00=blank.
//     Any other value is invalid.
//   - FSM, evaluated only on the edge where a pattern first becomes stable:
//       EMPTY/HELD, stable pattern == last_accepted: no event (glitch-and-return suppressed).
//       valid digit d: digit<=d, digit_valid=1, digit_count++, last_accepted<=pattern, ->HELD.
//         If the prior state was HELD (locked=1) and d != (digit==9 ? 0 : digit+1), seq_err=1.
//         In that case err_count++.
//         If locked=0 (first digit after reset/blank/error), no sequence check is made.
//       blank: locked<=0, last_accepted<=00, no pulse, ->EMPTY.
//       invalid: pattern_err=1, err_count++, locked<=0, last_accepted<=pattern, ->EMPTY.
//   - locked = (state == HELD).
//   - Each stable pattern fires at most once. It must change and restabilise to fire again.
//   - Mid-window changes restart the window. Toggling faster than STABLE_CYCLES gives no events.
//   - 9->0 is in order. Any other decrease, repeat-after-blank-free skip, or jump is seq_err.
//   - Counters never wrap. digit holds its value through blank/error.
// STRUCTURE
//   - Shared include seven_seg_defs.vh holds: SEG_0..SEG_9, SEG_BLANK, SEG_DP_MASK.
//     The encoder uses the same constants, so the table lives in one place.
//   - One sub-module, seg_to_bcd: combinational pattern -> {valid, blank, bcd[3:0]}.
//     The top level holds the input register, stability counter, FSM and counters.
// TESTING
//   1. Reset, seg_in=FC held 20 cycles -> single digit_valid, digit=0, locked=1, digit_count=1.
//      The pulse falls exactly STABLE_CYCLES+1 edges after the first sample.
//   2. Step FC,60,DA,...,F6,FC, 20 cycles each -> 11 pulses, digits 0..9,0.
//      Expect seq_err never, err_count=0, digit_count=11.
//   3. Locked on 3 (F2), then apply B6 (5) -> digit_valid with seq_err=1, digit=5, err_count=1.
//   4. Locked on 4, apply 8'h12 for 20 cycles -> pattern_err=1, locked=0.
//      Then apply 66 (4) -> digit_valid, no seq_err.
//   5. Locked on 7 (E0), glitch to 60 for 5 cycles, back to E0 -> no pulses, locked stays 1.
//   6. Assert rst during cycle 10 of a stability window for DA -> all outputs 0 next edge.
//      After release, DA held 20 cycles -> digit_valid, digit=2, no seq_err.

Source files
------------

// File: rtl/seven_seg_reader_pkg.sv
// Shared definitions for the seven-segment bus (encoder and reader).
// Segment byte layout: bit7=a, bit6=b, ... bit1=g, bit0=dp.
// Holds the segment table, the reader FSM state type and a BCD successor helper.
package seven_seg_reader_pkg;

    localparam logic [7:0] SEG_0       = 8'hFC;
    localparam logic [7:0] SEG_1       = 8'h60;
    localparam logic [7:0] SEG_2       = 8'hDA;
    localparam logic [7:0] SEG_3       = 8'hF2;
    localparam logic [7:0] SEG_4       = 8'h66;
    localparam logic [7:0] SEG_5       = 8'hB6;
    localparam logic [7:0] SEG_6       = 8'hBE;
    localparam logic [7:0] SEG_7       = 8'hE0;
    localparam logic [7:0] SEG_8       = 8'hFE;
    localparam logic [7:0] SEG_9       = 8'hF6;
    localparam logic [7:0] SEG_BLANK   = 8'h00;
    localparam logic [7:0] SEG_DP_MASK = 8'hFE;

    typedef enum logic {
        StEmpty = 1'b0,
        StHeld  = 1'b1
    } state_e;

    // Next digit in count order, 9 wraps to 0.
    function automatic logic [3:0] next_bcd(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/seven_seg_reader_seg_to_bcd.sv
// Combinational segment pattern decoder.
// Ports:
//   pattern  in  8  segment byte, dp already masked
//   valid    out 1  pattern is one of the ten digits
//   blank    out 1  pattern is all segments off
//   bcd      out 4  decoded digit (0 when not valid)
module seven_seg_reader_seg_to_bcd
    import seven_seg_reader_pkg::*;
(
    input  logic [7:0] pattern,
    output logic       valid,
    output logic       blank,
    output logic [3:0] bcd
);

    always_comb begin
        valid = 1'b1;
        blank = 1'b0;
        bcd   = 4'd0;
        case (pattern)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: begin
                valid = 1'b0;
                blank = 1'b1;
            end
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_reader.sv
// Receive side of the seven-segment LED bus. Debounces the segment byte, decodes each
// newly stable pattern to BCD and checks that digits arrive in count order.
// Ports:
//   clk          in   1   system clock
//   rst          in   1   synchronous reset, active-high
//   seg_in       in   8   segment byte (bit0 = dp, ignored)
//   digit_valid  out  1   one-cycle pulse, new digit accepted
//   digit        out  4   last accepted digit, held between pulses
//   pattern_err  out  1   one-cycle pulse, stable pattern neither digit nor blank
//   seq_err      out  1   one-cycle pulse with digit_valid, digit out of order
//   locked       out  1   a digit is held and no blank/error has followed
//   digit_count  out  16  accepted digits, saturating
//   err_count    out  8   pattern_err + seq_err events, saturating
module seven_seg_reader
    import seven_seg_reader_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 5,
    parameter bit          SEQ_CHECK     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_in,
    output logic        digit_valid,
    output logic [3:0]  digit,
    output logic        pattern_err,
    output logic        seq_err,
    output logic        locked,
    output logic [15:0] digit_count,
    output logic [7:0]  err_count
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);
    // Counter value one step before saturation; reaching CntMax on this edge means
    // the pattern first becomes stable now.
    localparam logic [CNT_W-1:0] CntPre = CNT_W'(STABLE_CYCLES - 2);

    logic [7:0]       seg_q;
    logic [7:0]       seg_prev;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       last_accepted;
    state_e           state;

    logic       dec_valid;
    logic       dec_blank;
    logic [3:0] dec_bcd;
    logic       fire;
    logic       seq_hit;
    logic [1:0] err_inc;
    logic [8:0] err_sum;
    logic [7:0] err_next;

    seven_seg_reader_seg_to_bcd u_dec (
        .pattern (seg_prev),
        .valid   (dec_valid),
        .blank   (dec_blank),
        .bcd     (dec_bcd)
    );

    // Input register and stability counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q    <= 8'h00;
            seg_prev <= 8'h00;
            cnt      <= '0;
        end else begin
            seg_q    <= seg_in & SEG_DP_MASK;
            seg_prev <= seg_q;
            if (seg_q != seg_prev) begin
                cnt <= '0;
            end else if (cnt != CntMax) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        // Same pattern as last accepted (glitch-and-return) is ignored.
        fire    = (seg_q == seg_prev) && (cnt == CntPre) && (seg_prev != last_accepted);
        seq_hit = SEQ_CHECK && (state == StHeld) && (dec_bcd != next_bcd(digit));
        err_inc = 2'd0;
        if (fire && dec_valid && seq_hit) begin
            err_inc = err_inc + 2'd1;
        end
        if (fire && !dec_valid && !dec_blank) begin
            err_inc = err_inc + 2'd1;
        end
        err_sum  = {1'b0, err_count} + {7'd0, err_inc};
        err_next = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StEmpty;
            last_accepted <= 8'h00;
            digit         <= 4'd0;
            digit_valid   <= 1'b0;
            pattern_err   <= 1'b0;
            seq_err       <= 1'b0;
            digit_count   <= 16'd0;
            err_count     <= 8'd0;
        end else begin
            digit_valid <= 1'b0;
            pattern_err <= 1'b0;
            seq_err     <= 1'b0;
            err_count   <= err_next;
            if (fire) begin
                if (dec_valid) begin
                    digit         <= dec_bcd;
                    digit_valid   <= 1'b1;
                    seq_err       <= seq_hit;
                    last_accepted <= seg_prev;
                    state         <= StHeld;
                    if (digit_count != 16'hFFFF) begin
                        digit_count <= digit_count + 16'd1;
                    end
                end else if (dec_blank) begin
                    last_accepted <= SEG_BLANK;
                    state         <= StEmpty;
                end else begin
                    pattern_err   <= 1'b1;
                    last_accepted <= seg_prev;
                    state         <= StEmpty;
                end
            end
        end
    end

    assign locked = (state == StHeld);

endmodule

// File: tb/tb_seven_seg_reader.sv
module tb_seven_seg_reader;

    localparam int S = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg_in;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        pattern_err;
    logic        seq_err;
    logic        locked;
    logic [15:0] digit_count;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_digit;
        logic [3:0] d;
        bit         seq;
    } exp_t;

    exp_t exp_q[$];

    seven_seg_reader #(
        .STABLE_CYCLES (S),
        .CNT_W         (5),
        .SEQ_CHECK     (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .digit_valid (digit_valid),
        .digit       (digit),
        .pattern_err (pattern_err),
        .seq_err     (seq_err),
        .locked      (locked),
        .digit_count (digit_count),
        .err_count   (err_count)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected event per observed pulse.
    always @(posedge clk) begin
        #1;
        if (digit_valid || pattern_err) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got dv=%0b pe=%0b digit=%0d, expected none",
                         digit_valid, pattern_err, digit);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_digit) begin
                    if (!(digit_valid && !pattern_err && digit == e.d && seq_err == e.seq)) begin
                        errors++;
                        $display("FAIL digit_event: got dv=%0b pe=%0b digit=%0d seq=%0b, expected digit=%0d seq=%0b",
                                 digit_valid, pattern_err, digit, seq_err, e.d, e.seq);
                    end
                end else if (!(pattern_err && !digit_valid && !seq_err)) begin
                    errors++;
                    $display("FAIL pattern_event: got dv=%0b pe=%0b seq=%0b, expected pattern_err only",
                             digit_valid, pattern_err, seq_err);
                end
            end
        end else if (seq_err) begin
            checks++;
            errors++;
            $display("FAIL lone_seq_err: got seq_err=1 without digit_valid, expected 0");
        end
    end

    task automatic push_digit(input logic [3:0] d, input bit seq);
        exp_t e;
        e.is_digit = 1'b1;
        e.d        = d;
        e.seq      = seq;
        exp_q.push_back(e);
    endtask

    task automatic push_perr();
        exp_t e;
        e.is_digit = 1'b0;
        e.d        = 4'd0;
        e.seq      = 1'b0;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic apply(input logic [7:0] p, input int cycles);
        seg_in = p;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic do_reset();
        seg_in = 8'h00;
        rst    = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dv"},     32'(digit_valid), 32'd0);
        chk({tag, "_digit"},  32'(digit),       32'd0);
        chk({tag, "_perr"},   32'(pattern_err), 32'd0);
        chk({tag, "_serr"},   32'(seq_err),     32'd0);
        chk({tag, "_locked"}, 32'(locked),      32'd0);
        chk({tag, "_dcnt"},   32'(digit_count), 32'd0);
        chk({tag, "_ecnt"},   32'(err_count),   32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] seq_pats [11];
        int rise;
        int fall;

        seq_pats = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6, 8'hFC};
        rst    = 1'b1;
        seg_in = 8'h00;
        @(negedge clk);
        do_reset();
        chk_all_zero("reset");

        // 1: single digit 0 and pulse timing.
        seg_in = 8'hFC;
        push_digit(4'd0, 1'b0);
        rise = 0;
        fall = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (digit_valid && rise == 0) rise = k;
            if (!digit_valid && rise != 0 && fall == 0) fall = k;
        end
        @(negedge clk);
        chk("t1_rise_edge", 32'(rise), 32'(S + 1));
        chk("t1_fall_edge", 32'(fall), 32'(S + 2));
        chk("t1_digit",  32'(digit),       32'd0);
        chk("t1_locked", 32'(locked),      32'd1);
        chk("t1_dcnt",   32'(digit_count), 32'd1);

        // 2: full count 0..9,0 with wrap.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            push_digit((i == 10) ? 4'd0 : 4'(i), 1'b0);
            apply(seq_pats[i], 20);
        end
        chk("t2_ecnt",   32'(err_count),   32'd0);
        chk("t2_dcnt",   32'(digit_count), 32'd11);
        chk("t2_digit",  32'(digit),       32'd0);

        // 3: skip 3 -> 5.
        do_reset();
        push_digit(4'd3, 1'b0);
        apply(8'hF2, 20);
        push_digit(4'd5, 1'b1);
        apply(8'hB6, 20);
        chk("t3_digit",  32'(digit),       32'd5);
        chk("t3_ecnt",   32'(err_count),   32'd1);
        chk("t3_dcnt",   32'(digit_count), 32'd2);
        chk("t3_locked", 32'(locked),      32'd1);

        // 4: invalid pattern, recovery without seq check, then blank.
        do_reset();
        push_digit(4'd4, 1'b0);
        apply(8'h66, 20);
        push_perr();
        apply(8'h12, 20);
        chk("t4_locked_err", 32'(locked),    32'd0);
        chk("t4_digit_held", 32'(digit),     32'd4);
        chk("t4_ecnt",       32'(err_count), 32'd1);
        push_digit(4'd4, 1'b0);
        apply(8'h66, 20);
        chk("t4_locked_re",  32'(locked),      32'd1);
        chk("t4_dcnt",       32'(digit_count), 32'd2);
        apply(8'h00, 20);
        chk("t4_locked_blank", 32'(locked), 32'd0);
        chk("t4_digit_blank",  32'(digit),  32'd4);
        push_digit(4'd9, 1'b0);
        apply(8'hF7, 20);  // dp set, must be ignored
        chk("t4_digit_9",   32'(digit),       32'd9);
        chk("t4_ecnt_end",  32'(err_count),   32'd1);

        // 5: glitch-and-return produces nothing.
        do_reset();
        push_digit(4'd7, 1'b0);
        apply(8'hE0, 20);
        apply(8'h60, 5);
        apply(8'hE0, 20);
        chk("t5_locked", 32'(locked),      32'd1);
        chk("t5_dcnt",   32'(digit_count), 32'd1);
        chk("t5_digit",  32'(digit),       32'd7);

        // 6: reset mid-window.
        apply(8'hDA, 10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("t6_reset");
        @(negedge clk);
        rst = 1'b0;
        push_digit(4'd2, 1'b0);
        apply(8'hDA, 20);
        chk("t6_digit", 32'(digit),       32'd2);
        chk("t6_dcnt",  32'(digit_count), 32'd1);
        chk("t6_ecnt",  32'(err_count),   32'd0);

        repeat (4) @(negedge clk);
        chk("pending_events", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
